gcd_lcm_coproc: RTL and testbench

//  Multi-cycle GCD/LCM coprocessor downstream of the single-cycle RISC-V core.
//  The core pulses Start with two register operands and an op select; this

---
 rtl/gcd_lcm_coproc_if.sv | 32 +++
 rtl/gcd_lcm_coproc.sv | 158 +++++++++++++++
 tb/tb_gcd_lcm_coproc.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_lcm_coproc_if.sv
// Core-side request/response bundle for the GCD/LCM coprocessor.
// The Ovf wire only exists when LCM_OVF_EN is defined.
interface gcd_lcm_coproc_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic             Op;
    logic [WIDTH-1:0] OpA;
    logic [WIDTH-1:0] OpB;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Result;
`ifdef LCM_OVF_EN
    logic             Ovf;
`endif

    modport master (
        output Start, Op, OpA, OpB,
`ifdef LCM_OVF_EN
        input  Ovf,
`endif
        input  Busy, Done, Result
    );

    modport slave (
        input  Start, Op, OpA, OpB,
`ifdef LCM_OVF_EN
        output Ovf,
`endif
        output Busy, Done, Result
    );
endinterface

// File: rtl/gcd_lcm_coproc.sv
// Multi-cycle GCD/LCM unit: subtractive Euclid, then restoring divide and shift-add multiply for LCM.
// Optional feature macro LCM_OVF_EN adds the Ovf flag (LCM wider than WIDTH bits).
module gcd_lcm_coproc #(
    parameter int WIDTH = 32
) (
    input logic             clk,
    input logic             reset,
    gcd_lcm_coproc_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GCD,
        S_DIV,
        S_MUL,
        S_DONE
    } state_e;

    state_e               state_q;
    logic                 op_q;
    // a_q/b_q hold the Euclid pair, then are reused as quotient and remainder in DIV
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     opa0_q;
    logic [WIDTH-1:0]     opb0_q;
    logic [WIDTH-1:0]     g_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CW-1:0]        cnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic [WIDTH-1:0]     res_q;
`ifdef LCM_OVF_EN
    logic                 ovf_q;
`endif

    logic [WIDTH:0]       rem_sh_d;
    logic [WIDTH:0]       rem_diff_d;
    logic                 qbit_d;
    logic [WIDTH-1:0]     rem_d;
    logic [WIDTH-1:0]     quo_d;
    logic [WIDTH:0]       mul_sum_d;
    logic [2*WIDTH-1:0]   acc_d;

    always_comb begin
        rem_sh_d   = {b_q, a_q[WIDTH-1]};
        rem_diff_d = rem_sh_d - {1'b0, g_q};
        qbit_d     = (rem_sh_d >= {1'b0, g_q});
        rem_d      = qbit_d ? rem_diff_d[WIDTH-1:0] : rem_sh_d[WIDTH-1:0];
        quo_d      = {a_q[WIDTH-2:0], qbit_d};
        // low half of acc holds the remaining multiplier bits, LSB consumed first
        mul_sum_d  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, opb0_q} : {(WIDTH+1){1'b0}});
        acc_d      = {mul_sum_d, acc_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            opa0_q  <= '0;
            opb0_q  <= '0;
            g_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
`ifdef LCM_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.Start) begin
                        a_q    <= bus.OpA;
                        b_q    <= bus.OpB;
                        opa0_q <= bus.OpA;
                        opb0_q <= bus.OpB;
                        op_q   <= bus.Op;
                        busy_q <= 1'b1;
                        if (bus.OpA == '0 || bus.OpB == '0) begin
                            res_q   <= bus.Op ? '0 : (bus.OpA | bus.OpB);
`ifdef LCM_OVF_EN
                            ovf_q   <= 1'b0;
`endif
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_GCD;
                        end
                    end
                end
                S_GCD: begin
                    if (a_q == b_q) begin
                        g_q <= a_q;
                        if (!op_q) begin
                            res_q   <= a_q;
`ifdef LCM_OVF_EN
                            ovf_q   <= 1'b0;
`endif
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            a_q     <= opa0_q;
                            b_q     <= '0;
                            cnt_q   <= '0;
                            state_q <= S_DIV;
                        end
                    end else if (a_q > b_q) begin
                        a_q <= a_q - b_q;
                    end else begin
                        b_q <= b_q - a_q;
                    end
                end
                S_DIV: begin
                    a_q   <= quo_d;
                    b_q   <= rem_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        acc_q   <= {{WIDTH{1'b0}}, quo_d};
                        cnt_q   <= '0;
                        state_q <= S_MUL;
                    end
                end
                S_MUL: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        res_q   <= acc_d[WIDTH-1:0];
`ifdef LCM_OVF_EN
                        ovf_q   <= |acc_d[2*WIDTH-1:WIDTH];
`endif
                        cnt_q   <= '0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.Busy   = busy_q;
    assign bus.Done   = done_q;
    assign bus.Result = res_q;
`ifdef LCM_OVF_EN
    assign bus.Ovf    = ovf_q;
`endif
endmodule

// File: tb/tb_gcd_lcm_coproc.sv
// Directed bench for gcd_lcm_coproc: arithmetic reference model checked every cycle,
// plus literal expectations per request. Honours LCM_OVF_EN for the Ovf checks.
module tb_gcd_lcm_coproc;
    localparam int W = 32;

    logic clk;
    logic reset;
    int   cyc;
    int   n_chk;
    int   n_fail;

    gcd_lcm_coproc_if #(.WIDTH(W)) bus ();

    gcd_lcm_coproc #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Euclid by remainder; the subtractive step count is the sum of quotients minus one
    function automatic logic [W-1:0] gcd_of(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int steps_of(input logic [W-1:0] x, input logic [W-1:0] y);
        longint n;
        logic [W-1:0] t;
        n = 0;
        while (y != 0) begin
            n += longint'(x / y);
            t = x % y;
            x = y;
            y = t;
        end
        return int'(n - 1);
    endfunction

    // reference model state, owned by the compare process
    bit           act;
    int           c0, dc;
    logic [W-1:0] m_res, p_res;
    logic         m_ovf, p_ovf;

    always @(negedge clk) begin
        logic         e_busy, e_done;
        logic [W-1:0] a, b, g;
        logic [2*W-1:0] prod;
        int           n;
        if (!reset) begin
            act   = 1'b0;
            m_res = '0;
            m_ovf = 1'b0;
            check("rst_busy", 64'(bus.Busy), 64'(0));
            check("rst_done", 64'(bus.Done), 64'(0));
            check("rst_result", 64'(bus.Result), 64'(0));
`ifdef LCM_OVF_EN
            check("rst_ovf", 64'(bus.Ovf), 64'(0));
`endif
        end else begin
            e_busy = act && cyc > c0 && cyc <= dc;
            e_done = act && cyc == dc;
            if (e_done) begin
                m_res = p_res;
                m_ovf = p_ovf;
            end
            check("busy", 64'(bus.Busy), 64'(e_busy));
            check("done", 64'(bus.Done), 64'(e_done));
            if (!e_busy || e_done) begin
                check("result", 64'(bus.Result), 64'(m_res));
`ifdef LCM_OVF_EN
                check("ovf", 64'(bus.Ovf), 64'(m_ovf));
`endif
            end
            if (bus.Start && !(act && cyc <= dc)) begin
                act = 1'b1;
                c0  = cyc;
                a   = bus.OpA;
                b   = bus.OpB;
                if (a == 0 || b == 0) begin
                    dc    = cyc + 1;
                    p_res = bus.Op ? '0 : (a | b);
                    p_ovf = 1'b0;
                end else begin
                    g = gcd_of(a, b);
                    n = steps_of(a, b);
                    if (!bus.Op) begin
                        dc    = cyc + n + 2;
                        p_res = g;
                        p_ovf = 1'b0;
                    end else begin
                        prod  = {{W{1'b0}}, a / g} * {{W{1'b0}}, b};
                        dc    = cyc + n + 2 + 2 * W;
                        p_res = prod[W-1:0];
                        p_ovf = |prod[2*W-1:W];
                    end
                end
            end
        end
    end

    task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_r, input logic exp_ovf, input int exp_lat,
                          input string nm);
        int s, t;
        @(posedge clk);
        #2;
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.OpA   = a;
        bus.OpB   = b;
        s         = cyc;
        @(posedge clk);
        #2;
        bus.Start = 1'b0;
        bus.Op    = 1'($urandom);
        bus.OpA   = $urandom;
        bus.OpB   = $urandom;
        t = 0;
        while (!bus.Done && t < 300) begin
            @(posedge clk);
            #2;
            t++;
        end
        check({nm, "_done_seen"}, 64'(bus.Done), 64'(1));
        check({nm, "_latency"}, 64'(cyc - s), 64'(exp_lat));
        check({nm, "_result"}, 64'(bus.Result), 64'(exp_r));
`ifdef LCM_OVF_EN
        check({nm, "_ovf"}, 64'(bus.Ovf), 64'(exp_ovf));
`else
        if (exp_ovf && 1'b0) $display("unused");
`endif
    endtask

    initial begin
        int s;
        n_chk     = 0;
        n_fail    = 0;
        reset     = 1'b0;
        bus.Start = 1'b0;
        bus.Op    = 1'b0;
        bus.OpA   = '0;
        bus.OpB   = '0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        check("init_busy", 64'(bus.Busy), 64'(0));
        check("init_result", 64'(bus.Result), 64'(0));

        run_op(1'b0, 48, 18, 6, 1'b0, 6, "gcd_48_18");
        run_op(1'b1, 4, 6, 12, 1'b0, 68, "lcm_4_6");
        repeat (10) @(posedge clk);
        #2 check("lcm_hold", 64'(bus.Result), 64'(12));

        run_op(1'b0, 0, 7, 7, 1'b0, 1, "gcd_0_7");
        run_op(1'b1, 0, 5, 0, 1'b0, 1, "lcm_0_5");
        run_op(1'b0, 0, 0, 0, 1'b0, 1, "gcd_0_0");
        run_op(1'b0, 18, 48, 6, 1'b0, 6, "gcd_18_48");
        run_op(1'b0, 35, 14, 7, 1'b0, 5, "gcd_35_14");
        run_op(1'b1, 21, 6, 42, 1'b0, 70, "lcm_21_6");
        run_op(1'b1, 32'hC000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 68, "lcm_ovf");

        // Start held through c1 and the DONE cycle must be ignored
        @(posedge clk);
        #2;
        bus.Start = 1'b1;
        bus.Op    = 1'b0;
        bus.OpA   = 13;
        bus.OpB   = 13;
        s         = cyc;
        @(posedge clk);
        #2;
        bus.OpA = 99;
        bus.OpB = 7;
        @(posedge clk);
        #2;
        check("ign_done_c2", 64'(bus.Done), 64'(1));
        check("ign_result", 64'(bus.Result), 64'(13));
        check("ign_cycle", 64'(cyc - s), 64'(2));
        @(posedge clk);
        #2;
        bus.Start = 1'b0;
        check("ign_idle_c3", 64'(bus.Busy), 64'(0));
        check("ign_hold_c3", 64'(bus.Result), 64'(13));

        // reset in the middle of an LCM
        @(posedge clk);
        #2;
        bus.Start = 1'b1;
        bus.Op    = 1'b1;
        bus.OpA   = 4;
        bus.OpB   = 6;
        s         = cyc;
        @(posedge clk);
        #2 bus.Start = 1'b0;
        while (cyc < s + 20) @(posedge clk);
        #2;
        check("pre_rst_busy", 64'(bus.Busy), 64'(1));
        reset = 1'b0;
        #1;
        check("mid_rst_busy", 64'(bus.Busy), 64'(0));
        check("mid_rst_done", 64'(bus.Done), 64'(0));
        check("mid_rst_result", 64'(bus.Result), 64'(0));
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        run_op(1'b0, 9, 6, 3, 1'b0, 4, "gcd_9_6_after_rst");
        repeat (3) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
